logcmp_issue: RTL
=================

Name: logcmp_issue

Overview:
- Issue queue and scheduler for the logCmp execution unit (SLT/SLTU, XOR, OR, AND and immediate forms).
- Buffers dispatched logCmp micro-ops and tracks source-operand readiness against the physical register-ready vector.
- Selects the oldest ready entry, reads its operands from the physical register file, and drives the registered logCmp_exeparam_vaild / logCmp_exeparam pair that the logCmp unit consumes.
- Sits between dispatch/rename and the logCmp unit; one issue per cycle.

Parameters:
- DEPTH, 4, number of queue entries (power of 2 not required, >=2).
- RNBIT, 2, rename bits per architectural register; physical tag width = 5+RNBIT.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; empties the queue and kills pending issue.
- dispatch_valid  in  1  dispatch offers a micro-op.
- dispatch_ready  out  1  queue can accept a micro-op this cycle.
- dispatch_fun  in  4  one-hot {slt,xor,or,and}.
- dispatch_isUsi  in  1  unsigned compare (SLTU/SLTIU).
- dispatch_rd0  in  5+RNBIT  destination physical tag.
- dispatch_rs1  in  5+RNBIT  source-1 physical tag.
- dispatch_rs2  in  5+RNBIT  source-2 physical tag; ignored when dispatch_isImm=1.
- dispatch_isImm  in  1  op2 is the immediate.
- dispatch_imm  in  64  sign-extended immediate.
- reg_ready  in  32*2^RNBIT  per-physical-register "value readable in regfile" bits.
- rs1_raddr  out  5+RNBIT  regfile read address for op1 (combinational from selection).
- rs1_rdata  in  64  regfile read data, same cycle.
- rs2_raddr  out  5+RNBIT  regfile read address for op2.
- rs2_rdata  in  64  regfile read data, same cycle.
- logCmp_exeparam_vaild  out  1  registered issue valid to logCmp.
- logCmp_exeparam  out  LOGCMP_EXEPARAM_DW  registered packed parameter {fun_slt,fun_xor,fun_or,fun_and,rd0,op1,op2,isUsi}.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - All entry valid bits are 0; count is 0.
  - logCmp_exeparam_vaild is 0 and logCmp_exeparam is all-zero.
  - dispatch_ready is 1 from the first cycle after reset.
  - Reset asserted mid-operation discards all entries and any in-flight issue; same effect as flush.
- Storage:
  - Collapsing, age-ordered queue; entry 0 is oldest and valid entries occupy 0..count-1 contiguously.
- Dispatch:
  - dispatch_ready = (count < DEPTH), registered-state only.
  - There is no full-queue bypass: when the queue is full, dispatch_ready=0 even if an issue happens the same cycle.
  - A dispatch is accepted when dispatch_valid & dispatch_ready.
- Readiness:
  - An entry is ready when reg_ready[rs1]=1 and (isImm=1 or reg_ready[rs2]=1), evaluated combinationally every cycle.
  - reg_ready=1 guarantees the regfile read returns the final value; the block does no bypassing.
- Select:
  - Picks the lowest-index ready entry.
  - rs1_raddr/rs2_raddr are driven from the selected entry; when nothing is selected they are driven from entry 0.
- Issue (at the CLK edge, when a ready entry is selected):
  - logCmp_exeparam_vaild <= 1.
  - logCmp_exeparam <= {fun, rd0, rs1_rdata, isImm ? imm : rs2_rdata, isUsi}.
  - The selected entry is removed; entries above it shift down by one.
  - If no entry is ready: logCmp_exeparam_vaild <= 0 and logCmp_exeparam holds its value.
- Simultaneous dispatch and issue:
  - The new entry is written at index count-1 (after collapse); otherwise it is written at index count.
  - count is unchanged.
- Latency:
  - A micro-op accepted at edge t is eligible at cycle t+1.
  - With operands ready, logCmp_exeparam_vaild rises after edge t+1, so issue is 1 cycle minimum after acceptance.
  - The logCmp writeback follows one further cycle later.
- Throughput: at most 1 issue per cycle; back-to-back issue is allowed.
- Flush:
  - At the edge where flush=1, all entries are invalidated, count is set to 0, and logCmp_exeparam_vaild is set to 0.
  - Dispatch and issue in that cycle are dropped.
  - Flush has priority over everything except RST.
- Illegal input:
  - dispatch_fun must be one-hot. A non-one-hot value is stored as given.
  - Verification flags it with an assertion; it is not legal stimulus.

Decomposition:
- Shared package/define header:
  - LOGCMP_EXEPARAM_DW = 4+(5+RNBIT)+64+64+1.
  - Funct one-hot bit positions.
  - Physical tag width macro (5+RNBIT).
  - Queue-entry struct/field layout {fun, isUsi, isImm, rd0, rs1, rs2, imm}.
- One sub-module is natural: logcmp_issue_select, combinational oldest-ready priority picker over the DEPTH ready vector, producing one-hot select and index.
- Output registers use gen_dffr-style flops with synchronous active-high reset.

Test Plan:
- Reset, then idle: logCmp_exeparam_vaild=0, logCmp_exeparam=0, dispatch_ready=1, both read addresses driven from entry 0.
- Ready XOR: dispatch xor, rd0=9, rs1=3 (data 0xF0F0), rs2=4 (data 0x0FF0), both ready -> one cycle later vaild=1, exeparam={0100,9,0xF0F0,0x0FF0,0}; following cycle vaild=0.
- Out-of-order wakeup:
  - Dispatch A (rs1=5, not ready) then B (SLTIU, rs1=6 data 1, imm=2, isUsi=1, ready).
  - Expect B issues first with op2=2.
  - Set reg_ready[5] -> A issues next cycle.
- Oldest-first tie: three ready entries in the queue -> issue order 0,1,2 on consecutive cycles; count decrements by 1 per cycle.
- Full plus collapse:
  - Fill DEPTH=4 entries, none ready -> dispatch_ready=0 and offered op not accepted.
  - Make entry 2 ready -> it issues; next cycle dispatch_ready=1; a new dispatch lands at index 3.
  - Original order of entries 0,1,3 is preserved.
- Flush/reset mid-stream:
  - 3 entries queued, one issuing, with flush and dispatch_valid in the same cycle -> next cycle vaild=0, count=0, dispatch not accepted, no later issue of old entries.
  - Repeat with RST instead of flush: same result.

Source files
------------

// File: rtl/logcmp_issue_pkg.sv
// Shared constants for the logCmp issue queue: funct one-hot positions, field widths and
// the packed execute-parameter width.
package logcmp_issue_pkg;

    localparam int unsigned RNBIT_DEF = 2;
    localparam int unsigned FUN_W     = 4;
    localparam int unsigned DATA_W    = 64;

    // Bit positions inside the one-hot {slt,xor,or,and} funct field.
    localparam int unsigned FUN_AND = 0;
    localparam int unsigned FUN_OR  = 1;
    localparam int unsigned FUN_XOR = 2;
    localparam int unsigned FUN_SLT = 3;

    function automatic int unsigned tag_w(int unsigned rnbit);
        return 5 + rnbit;
    endfunction

    // {fun, rd0, op1, op2, isUsi}
    function automatic int unsigned exeparam_dw(int unsigned rnbit);
        return FUN_W + tag_w(rnbit) + 2 * DATA_W + 1;
    endfunction

endpackage

// File: rtl/logcmp_issue_select.sv
// Oldest-ready picker: the lowest-index set bit of the ready vector wins.
module logcmp_issue_select #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] ready_i,
    output logic [DEPTH-1:0] sel_oh_o,
    output logic [IDX_W-1:0] sel_idx_o,
    output logic             sel_valid_o
);

    always_comb begin
        sel_oh_o    = '0;
        sel_idx_o   = '0;
        sel_valid_o = 1'b0;
        // Scan from the top so the lowest ready index is the last one written.
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (ready_i[i]) begin
                sel_oh_o    = '0;
                sel_oh_o[i] = 1'b1;
                sel_idx_o   = IDX_W'(i);
                sel_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/logcmp_issue.sv
// Collapsing age-ordered issue queue for the logCmp unit: tracks operand readiness, issues the
// oldest ready micro-op each cycle and registers its execute parameters.
module logcmp_issue
    import logcmp_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RNBIT = RNBIT_DEF,
    localparam int unsigned TAG_W = tag_w(RNBIT),
    localparam int unsigned NREG = 32 * (2 ** RNBIT),
    localparam int unsigned LOGCMP_EXEPARAM_DW = exeparam_dw(RNBIT)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          flush,
    input  logic                          dispatch_valid,
    output logic                          dispatch_ready,
    input  logic [FUN_W-1:0]              dispatch_fun,
    input  logic                          dispatch_isUsi,
    input  logic [TAG_W-1:0]              dispatch_rd0,
    input  logic [TAG_W-1:0]              dispatch_rs1,
    input  logic [TAG_W-1:0]              dispatch_rs2,
    input  logic                          dispatch_isImm,
    input  logic [DATA_W-1:0]             dispatch_imm,
    input  logic [NREG-1:0]               reg_ready,
    output logic [TAG_W-1:0]              rs1_raddr,
    input  logic [DATA_W-1:0]             rs1_rdata,
    output logic [TAG_W-1:0]              rs2_raddr,
    input  logic [DATA_W-1:0]             rs2_rdata,
    output logic                          logCmp_exeparam_vaild,
    output logic [LOGCMP_EXEPARAM_DW-1:0] logCmp_exeparam
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [FUN_W-1:0]  fun;
        logic              is_usi;
        logic              is_imm;
        logic [TAG_W-1:0]  rd0;
        logic [TAG_W-1:0]  rs1;
        logic [TAG_W-1:0]  rs2;
        logic [DATA_W-1:0] imm;
    } entry_t;

    entry_t                        q_q [DEPTH];
    entry_t                        q_d [DEPTH];
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          vaild_q, vaild_d;
    logic [LOGCMP_EXEPARAM_DW-1:0] param_q, param_d;

    logic [DEPTH-1:0] ent_ready;
    logic [DEPTH-1:0] sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    entry_t           sel_ent;
    entry_t           new_ent;
    logic             accept;
    logic [CNT_W-1:0] wr_idx;
    logic [DATA_W-1:0] op2;
    logic             shift;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ent_ready[i] = (CNT_W'(i) < count_q) && reg_ready[q_q[i].rs1] &&
                           (q_q[i].is_imm || reg_ready[q_q[i].rs2]);
        end
    end

    logcmp_issue_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .ready_i     (ent_ready),
        .sel_oh_o    (sel_oh),
        .sel_idx_o   (sel_idx),
        .sel_valid_o (sel_valid)
    );

    assign sel_ent        = sel_valid ? q_q[sel_idx] : q_q[0];
    assign rs1_raddr      = sel_ent.rs1;
    assign rs2_raddr      = sel_ent.rs2;
    assign op2            = sel_ent.is_imm ? sel_ent.imm : rs2_rdata;
    assign dispatch_ready = count_q < CNT_W'(DEPTH);
    assign accept         = dispatch_valid && dispatch_ready;
    // With a same-cycle issue the queue collapses first, so the new slot is one lower.
    assign wr_idx         = count_q - CNT_W'(sel_valid);

    assign new_ent = '{
        fun:    dispatch_fun,
        is_usi: dispatch_isUsi,
        is_imm: dispatch_isImm,
        rd0:    dispatch_rd0,
        rs1:    dispatch_rs1,
        rs2:    dispatch_rs2,
        imm:    dispatch_imm
    };

    always_comb begin
        q_d     = q_q;
        count_d = count_q + CNT_W'(accept) - CNT_W'(sel_valid);
        vaild_d = 1'b0;
        param_d = param_q;
        shift   = 1'b0;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            shift = shift | sel_oh[i];
            if (shift) begin
                q_d[i] = q_q[i+1];
            end
        end
        if (accept) begin
            q_d[wr_idx[IDX_W-1:0]] = new_ent;
        end
        if (sel_valid) begin
            vaild_d = 1'b1;
            param_d = {sel_ent.fun[FUN_SLT], sel_ent.fun[FUN_XOR], sel_ent.fun[FUN_OR],
                       sel_ent.fun[FUN_AND], sel_ent.rd0, rs1_rdata, op2, sel_ent.is_usi};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_q[i] <= '0;
            end
            count_q <= '0;
            vaild_q <= 1'b0;
            param_q <= '0;
        end else if (flush) begin
            count_q <= '0;
            vaild_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
            vaild_q <= vaild_d;
            param_q <= param_d;
        end
    end

    assign logCmp_exeparam_vaild = vaild_q;
    assign logCmp_exeparam       = param_q;

    assert property (@(posedge CLK) disable iff (RST) (accept |-> $onehot(dispatch_fun)))
        else $error("logcmp_issue: dispatch_fun is not one-hot");

endmodule
